// File: rtl/click_to_sync_bridge_if.sv
// Bundled-data link between an asynchronous click stage and a clocked consumer.
// The slave side is the bridge: it receives inR/inData and returns outA.
interface click_to_sync_bridge_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  inR;
  logic [DATA_WIDTH-1:0] inData;
  logic                  outA;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  inR,
    input  inData,
    input  out_ready,
    output outA,
    output out_valid,
    output out_data
  );

  modport master (
    output inR,
    output inData,
    output out_ready,
    input  outA,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/click_to_sync_bridge.sv
// Brings a 2-phase bundled-data request into the clk domain, presents the word
// on valid/ready and returns a 2-phase acknowledge once the word is taken.
module click_to_sync_bridge #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  click_to_sync_bridge_if.slave link,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic [SYNC_STAGES-1:0]  sync_next;
  logic                    r_prev;
  logic                    ack_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    err_reg;
  logic [CNT_WIDTH-1:0]    cnt_reg;

  logic s_last;
  logic tog;
  logic valid;
  logic capture;
  logic accept;
  logic err_set;

  // Only inR is synchronised; the synchroniser depth is the bundling margin for inData.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = link.inR;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign s_last = sync_reg[SYNC_STAGES-1];
  assign tog    = s_last ^ r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (tog)            state_next = HOLD;
      HOLD:    if (link.out_ready) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // A toggle seen while holding is a protocol violation: flag it, never capture it.
  always_comb begin
    valid   = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    err_set = 1'b0;
    unique case (state_reg)
      IDLE: begin
        capture = tog;
      end
      HOLD: begin
        valid   = 1'b1;
        accept  = link.out_ready;
        err_set = tog;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
      r_prev   <= 1'b0;
      ack_reg  <= 1'b0;
      data_reg <= '0;
      err_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= sync_next;
      if (tog) begin
        r_prev <= s_last;
      end
      if (capture) begin
        data_reg <= link.inData;
      end
      if (accept) begin
        ack_reg <= ~ack_reg;
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
      if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign link.outA      = ack_reg;
  assign link.out_valid = valid;
  assign link.out_data  = data_reg;
  assign proto_err      = err_reg;
  assign xfer_cnt       = cnt_reg;

endmodule
